// File: rtl/paddle_drive_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : paddle_drive_ctrl
// Brief    : Arbitrates player keys and ball-tracking auto-pilot into one
//            up/down pulse per movement tick for the paddle mover.
// Revision : 1.0 - initial release
// ============================================================================
module paddle_drive_ctrl #(
  parameter logic [19:0] TICK_DIV   = 20'd416666,
  parameter logic [7:0]  HOLD_TICKS = 8'd120,
  parameter logic [9:0]  DEADBAND   = 10'd4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inPlay,
  input  logic       keyUp,
  input  logic       keyDown,
  input  logic [9:0] ballY,
  input  logic [9:0] paddleY,
  output logic       up,
  output logic       down,
  output logic       owner,
  output logic       tick
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_AUTO   = 2'd1,
    S_MANUAL = 2'd2
  } state_t;

  localparam logic [19:0] c_tick_last = TICK_DIV - 20'd1;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_ku_meta;
  logic        r_ku;
  logic        r_kd_meta;
  logic        r_kd;
  logic [19:0] r_cnt;
  logic [7:0]  r_idle;
  logic [7:0]  w_idle_nxt;
  logic        r_up;
  logic        r_down;
  logic        w_up_nxt;
  logic        w_down_nxt;
  logic        w_tick;
  logic        w_active;
  logic [10:0] w_ball_lo;
  logic [10:0] w_pad_hi;

  assign w_tick    = (r_state != S_IDLE) && (r_cnt == c_tick_last);
  assign w_active  = r_ku | r_kd;
  // One spare bit so adding the dead zone near the top of the range cannot wrap.
  assign w_ball_lo = {1'b0, ballY} + {1'b0, DEADBAND};
  assign w_pad_hi  = {1'b0, paddleY} + {1'b0, DEADBAND};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ku_meta <= 1'b0;
      r_ku      <= 1'b0;
      r_kd_meta <= 1'b0;
      r_kd      <= 1'b0;
    end else begin
      r_ku_meta <= keyUp;
      r_ku      <= r_ku_meta;
      r_kd_meta <= keyDown;
      r_kd      <= r_kd_meta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= 20'd0;
    end else if (r_state == S_IDLE || w_tick) begin
      r_cnt <= 20'd0;
    end else begin
      r_cnt <= r_cnt + 20'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idle  <= 8'd0;
      r_up    <= 1'b0;
      r_down  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idle  <= w_idle_nxt;
      r_up    <= w_up_nxt;
      r_down  <= w_down_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle;
    w_up_nxt    = 1'b0;
    w_down_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_idle_nxt = 8'd0;
        if (inPlay) w_state_nxt = S_AUTO;
      end
      S_AUTO: begin
        if (w_tick) begin
          w_up_nxt   = (w_ball_lo < {1'b0, paddleY});
          w_down_nxt = ({1'b0, ballY} > w_pad_hi);
        end
        if (w_active) begin
          w_state_nxt = S_MANUAL;
          w_idle_nxt  = 8'd0;
        end
      end
      S_MANUAL: begin
        if (w_tick) begin
          w_up_nxt   = r_ku & ~r_kd;
          w_down_nxt = r_kd & ~r_ku;
          if (w_active) begin
            w_idle_nxt = 8'd0;
          end else if (r_idle + 8'd1 == HOLD_TICKS) begin
            w_state_nxt = S_AUTO;
            w_idle_nxt  = 8'd0;
          end else begin
            w_idle_nxt = r_idle + 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idle_nxt  = 8'd0;
      end
    endcase
    // Pausing overrides everything, including a command due this tick.
    if (!inPlay) begin
      w_state_nxt = S_IDLE;
      w_idle_nxt  = 8'd0;
      w_up_nxt    = 1'b0;
      w_down_nxt  = 1'b0;
    end
  end

  assign up    = r_up;
  assign down  = r_down;
  assign owner = (r_state == S_MANUAL);
  assign tick  = w_tick;

endmodule
`default_nettype wire
